uart_bus_master: RTL and testbench

Serial-to-bus bridge: the initiator counterpart of the UART peripheral's simple slave interface. It receives 8N1 command frames on a UART rx line, issues single-cycle reads and writes on the simple interface (addr/re/we/wd/rd), and returns responses on a UART tx line. Used as a debug/boot master that can program any peripheral on the simple bus, including the UART peripheral itself, from a host PC.

---
 rtl/uart_bus_master.sv | 260 ++++++++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// UART-to-simple-bus bridge: 8N1 'W'/'R' command frames in, one-cycle re/we strobes out, 'K' / 4 read bytes / 'E' back.
// Strobe 1 cycle after the last command byte; response start bit 1 cycle after the strobe; no backpressure (bytes seen while responding are dropped).
module uart_bus_master #(
    parameter int unsigned TMO_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dfv,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic [4:0]  addr,
    output logic        re,
    output logic        we,
    output logic [31:0] wd,
    input  logic [31:0] rd,
    output logic        busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_ADDR = 3'd1;
    localparam logic [2:0] S_GET_DATA = 3'd2;
    localparam logic [2:0] S_BUS_WR   = 3'd3;
    localparam logic [2:0] S_BUS_RD   = 3'd4;
    localparam logic [2:0] S_RESP     = 3'd5;
    localparam logic [2:0] S_ERR      = 3'd6;

    logic [2:0]  state;
    logic [15:0] dv_eff;
    assign dv_eff = (dfv < 16'd4) ? 16'd4 : dfv;

    logic        in_frame;
    assign in_frame = (state == S_GET_ADDR) || (state == S_GET_DATA);

    // ---------------- receiver ----------------
    logic [1:0]  rx_sync;
    logic        rx_s, rx_prev;
    logic        rx_act, rx_disc;
    logic [3:0]  rx_bit;
    logic [15:0] rx_cnt, rx_lim, rx_dv;
    logic [7:0]  rx_sh, rx_dat;
    logic        rx_vld, rx_ferr;
    logic        rx_start, rx_tick;

    assign rx_s     = rx_sync[1];
    assign rx_start = !rx_act && rx_prev && !rx_s;
    assign rx_tick  = rx_act && (rx_cnt == rx_lim - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
            rx_act  <= 1'b0;
            rx_disc <= 1'b0;
            rx_bit  <= 4'd0;
            rx_cnt  <= 16'd0;
            rx_lim  <= 16'd0;
            rx_dv   <= 16'd4;
            rx_sh   <= 8'd0;
            rx_dat  <= 8'd0;
            rx_vld  <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx};
            rx_prev <= rx_s;
            rx_vld  <= 1'b0;
            rx_ferr <= 1'b0;
            if (rx_start) begin
                // bytes that begin while a command is being executed or answered are dropped
                rx_act  <= 1'b1;
                rx_disc <= !((state == S_IDLE) || in_frame);
                rx_bit  <= 4'd0;
                rx_cnt  <= 16'd0;
                rx_dv   <= dv_eff;
                rx_lim  <= {1'b0, dv_eff[15:1]};
            end else if (rx_act) begin
                if (rx_tick) begin
                    rx_cnt <= 16'd0;
                    rx_lim <= rx_dv;
                    if (rx_bit == 4'd0) begin
                        if (rx_s) rx_act <= 1'b0;
                        else      rx_bit <= 4'd1;
                    end else if (rx_bit < 4'd9) begin
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        rx_bit <= rx_bit + 4'd1;
                    end else begin
                        rx_act <= 1'b0;
                        if (!rx_disc) begin
                            rx_vld  <= rx_s;
                            rx_ferr <= !rx_s;
                            rx_dat  <= rx_sh;
                        end
                    end
                end else begin
                    rx_cnt <= rx_cnt + 16'd1;
                end
            end
        end
    end

    // ---------------- timeout ----------------
    logic [47:0] tmo_cnt, tmo_lim;
    logic        tmo_hit;
    assign tmo_lim = 48'(TMO_BITS) * 48'(rx_dv);
    assign tmo_hit = (TMO_BITS != 0) && in_frame && !rx_act && (tmo_cnt == tmo_lim - 48'd1);

    // ---------------- transmitter control ----------------
    logic        tx_act;
    logic [3:0]  tx_bit;
    logic [15:0] tx_cnt, tx_dv;
    logic [7:0]  tx_sh;
    logic [31:0] resp;
    logic [1:0]  n_left;
    logic        tx_tick, tx_end, tx_go;
    logic [7:0]  tx_go_byte;

    assign tx_tick = tx_act && (tx_cnt == tx_dv - 16'd1);
    assign tx_end  = tx_tick && (tx_bit == 4'd9);

    always_comb begin
        tx_go      = 1'b0;
        tx_go_byte = 8'd0;
        case (state)
            S_BUS_WR: begin tx_go = 1'b1; tx_go_byte = 8'h4B;    end
            S_BUS_RD: begin tx_go = 1'b1; tx_go_byte = rd[7:0];  end
            S_ERR:    begin tx_go = 1'b1; tx_go_byte = 8'h45;    end
            S_RESP: begin
                if (tx_end && (n_left != 2'd0)) begin
                    tx_go      = 1'b1;
                    tx_go_byte = resp[15:8];
                end
            end
            default: ;
        endcase
    end

    // ---------------- command FSM and serializer ----------------
    logic        is_wr;
    logic [1:0]  dcnt;
    logic [4:0]  abuf;
    logic [31:0] wbuf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            is_wr   <= 1'b0;
            dcnt    <= 2'd0;
            abuf    <= 5'd0;
            wbuf    <= 32'd0;
            addr    <= 5'd0;
            wd      <= 32'd0;
            tmo_cnt <= 48'd0;
            uart_tx <= 1'b1;
            tx_act  <= 1'b0;
            tx_bit  <= 4'd0;
            tx_cnt  <= 16'd0;
            tx_dv   <= 16'd4;
            tx_sh   <= 8'd0;
            resp    <= 32'd0;
            n_left  <= 2'd0;
        end else begin
            if (rx_start || rx_vld || !in_frame) tmo_cnt <= 48'd0;
            else if (!rx_act)                    tmo_cnt <= tmo_cnt + 48'd1;

            if (tx_go) begin
                uart_tx <= 1'b0;
                tx_act  <= 1'b1;
                tx_bit  <= 4'd0;
                tx_cnt  <= 16'd0;
                tx_dv   <= dv_eff;
                tx_sh   <= tx_go_byte;
            end else if (tx_act) begin
                if (tx_tick) begin
                    tx_cnt <= 16'd0;
                    if (tx_bit == 4'd9) begin
                        tx_act <= 1'b0;
                    end else begin
                        // ones shifted in behind the data become the stop bit
                        uart_tx <= tx_sh[0];
                        tx_sh   <= {1'b1, tx_sh[7:1]};
                        tx_bit  <= tx_bit + 4'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + 16'd1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (rx_vld) begin
                        if (rx_dat == 8'h57) begin
                            is_wr <= 1'b1;
                            state <= S_GET_ADDR;
                        end else if (rx_dat == 8'h52) begin
                            is_wr <= 1'b0;
                            state <= S_GET_ADDR;
                        end else begin
                            state <= S_ERR;
                        end
                    end
                end
                S_GET_ADDR: begin
                    if (rx_ferr || tmo_hit) begin
                        state <= S_IDLE;
                    end else if (rx_vld) begin
                        if (is_wr) begin
                            abuf  <= rx_dat[4:0];
                            dcnt  <= 2'd0;
                            state <= S_GET_DATA;
                        end else begin
                            addr  <= rx_dat[4:0];
                            state <= S_BUS_RD;
                        end
                    end
                end
                S_GET_DATA: begin
                    if (rx_ferr || tmo_hit) begin
                        state <= S_IDLE;
                    end else if (rx_vld) begin
                        wbuf <= {rx_dat, wbuf[31:8]};
                        dcnt <= dcnt + 2'd1;
                        if (dcnt == 2'd3) begin
                            wd    <= {rx_dat, wbuf[31:8]};
                            addr  <= abuf;
                            state <= S_BUS_WR;
                        end
                    end
                end
                S_BUS_WR: begin
                    n_left <= 2'd0;
                    state  <= S_RESP;
                end
                S_BUS_RD: begin
                    resp   <= rd;
                    n_left <= 2'd3;
                    state  <= S_RESP;
                end
                S_ERR: begin
                    n_left <= 2'd0;
                    state  <= S_RESP;
                end
                S_RESP: begin
                    if (tx_end) begin
                        if (n_left == 2'd0) begin
                            state <= S_IDLE;
                        end else begin
                            n_left <= n_left - 2'd1;
                            resp   <= resp >> 8;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign re   = (state == S_BUS_RD);
    assign we   = (state == S_BUS_WR);
    assign busy = (state != S_IDLE) || (rx_act && !rx_disc) || rx_vld;

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: directed scenarios plus random frames scored against a frame-level model.
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dfv;
    logic        uart_rx;
    logic        uart_tx;
    logic [4:0]  addr;
    logic        re, we, busy;
    logic [31:0] wd, rd;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int both_hi = 0;

    logic [31:0] periph [32];
    logic [31:0] ref_mem [32];

    logic [37:0] bus_q[$];
    logic [37:0] exp_bus[$];
    logic [8:0]  txq[$];
    logic [8:0]  exp_tx[$];
    int          txs_q[$];

    uart_bus_master #(.TMO_BITS(32)) dut (
        .clk(clk), .rst(rst), .dfv(dfv), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .addr(addr), .re(re), .we(we), .wd(wd), .rd(rd), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rd = periph[addr];

    function automatic int dv_of(input logic [15:0] f);
        return (f < 16'd4) ? 4 : int'(f);
    endfunction

    // Simple-bus peripheral: a 32-word register file.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (we === 1'b1) begin
                bus_q.push_back({1'b1, addr, wd});
                periph[addr] = wd;
            end
            if (re === 1'b1) bus_q.push_back({1'b0, addr, rd});
            if (re === 1'b1 && we === 1'b1) both_hi++;
        end
    end

    // UART receiver on the response line, sampling near bit centres.
    initial begin : txmon
        int d, s;
        logic [7:0] b;
        logic sb;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && uart_tx === 1'b0) begin
                s = cyc;
                d = dv_of(dfv);
                repeat (d / 2 - 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (d) @(negedge clk);
                sb = uart_tx;
                txq.push_back({sb, b});
                txs_q.push_back(s);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopv);
        int d;
        d = dv_of(dfv);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (d) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (d) @(negedge clk);
        end
        uart_rx = stopv;
        repeat (d) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    // Reference model: what each well-formed frame must produce on the bus and on uart_tx.
    task automatic send_write(input logic [7:0] a, input logic [31:0] d);
        send_byte(8'h57, 1'b1);
        send_byte(a, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
        exp_bus.push_back({1'b1, a[4:0], d});
        ref_mem[a[4:0]] = d;
        exp_tx.push_back({1'b1, 8'h4B});
    endtask

    task automatic send_read(input logic [7:0] a);
        logic [31:0] v;
        send_byte(8'h52, 1'b1);
        send_byte(a, 1'b1);
        v = ref_mem[a[4:0]];
        exp_bus.push_back({1'b0, a[4:0], v});
        for (int i = 0; i < 4; i++) exp_tx.push_back({1'b1, v[8*i +: 8]});
    endtask

    task automatic send_bad(input logic [7:0] c);
        send_byte(c, 1'b1);
        exp_tx.push_back({1'b1, 8'h45});
    endtask

    task automatic clear_q();
        bus_q.delete(); txq.delete(); txs_q.delete(); exp_bus.delete(); exp_tx.delete();
    endtask

    // Wait for the transaction to finish, then score bus strobes, response bytes and their timing.
    task automatic settle(input string tag);
        int n, fall, d, m;
        d = dv_of(dfv);
        n = 0;
        while (busy !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        fall = cyc;
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
        repeat (3 * d) @(negedge clk);
        chk({tag, "_nstrobe"}, 64'(bus_q.size()), 64'(exp_bus.size()));
        m = (bus_q.size() < exp_bus.size()) ? bus_q.size() : exp_bus.size();
        for (int i = 0; i < m; i++) chk({tag, "_strobe"}, 64'(bus_q[i]), 64'(exp_bus[i]));
        chk({tag, "_ntx"}, 64'(txq.size()), 64'(exp_tx.size()));
        m = (txq.size() < exp_tx.size()) ? txq.size() : exp_tx.size();
        for (int i = 0; i < m; i++) chk({tag, "_txbyte"}, 64'(txq[i]), 64'(exp_tx[i]));
        if (exp_tx.size() != 0 && txs_q.size() == exp_tx.size()) begin
            for (int i = 1; i < txs_q.size(); i++)
                chk({tag, "_tx_gap"}, 64'(txs_q[i] - txs_q[i-1]), 64'(10 * d));
            chk({tag, "_busy_fall"}, 64'(fall - txs_q[txs_q.size()-1]), 64'(10 * d));
        end
        clear_q();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] v;
        int kind;
        logic [7:0] a, c;
        for (int i = 0; i < 32; i++) begin
            v = $urandom;
            periph[i] = v;
            ref_mem[i] = v;
        end
        periph[4]  = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;

        rst = 1'b1; uart_rx = 1'b1; dfv = 16'd8;
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", 64'(uart_tx), 64'd1);
        chk("rst_addr",    64'(addr),    64'd0);
        chk("rst_re",      64'(re),      64'd0);
        chk("rst_we",      64'(we),      64'd0);
        chk("rst_wd",      64'(wd),      64'd0);
        chk("rst_busy",    64'(busy),    64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // write frame
        send_write(8'h03, 32'h12345678);
        settle("write");

        // read frame, four bytes back-to-back
        send_read(8'h04);
        settle("read");

        // unknown command byte, then a normal read
        send_bad(8'h41);
        settle("badcmd");
        send_read(8'h00);
        settle("after_bad");

        // partial frame abandoned: timeout drops it silently
        send_byte(8'h57, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (300) @(negedge clk);
        chk("tmo_busy", 64'(busy), 64'd0);
        settle("tmo");
        send_read(8'h01);
        settle("after_tmo");

        // short glitch is not a start bit
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_busy", 64'(busy), 64'd0);
        settle("glitch");

        // framing error on the address byte aborts the frame
        send_byte(8'h57, 1'b1);
        send_byte(8'h05, 1'b0);
        repeat (24) @(negedge clk);
        chk("ferr_busy", 64'(busy), 64'd0);
        settle("ferr");
        send_write(8'hE2, 32'hCAFEF00D);
        settle("after_ferr");

        // random frames, including bit periods below the minimum
        for (int k = 0; k < 8; k++) begin
            dfv = 16'($urandom_range(2, 12));
            kind = $urandom_range(0, 4);
            a = 8'($urandom);
            if (kind < 2) begin
                send_write(a, $urandom);
            end else if (kind < 4) begin
                send_read(a);
            end else begin
                c = 8'($urandom);
                if (c == 8'h57 || c == 8'h52) c = c ^ 8'h80;
                send_bad(c);
            end
            settle("rand");
        end

        // reset during the second response byte of a read
        dfv = 16'd8;
        send_read(8'h09);
        begin : wait_first
            int n;
            n = 0;
            while (txq.size() < 1 && n < 2000) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (20) @(negedge clk);
        chk("rstmid_strobe", 64'(bus_q.size() > 0 ? bus_q[0] : 38'd0), 64'(exp_bus[0]));
        chk("rstmid_byte0",  64'(txq.size() > 0 ? txq[0] : 9'd0), 64'(exp_tx[0]));
        rst = 1'b1;
        #1;
        chk("rstmid_uart_tx", 64'(uart_tx), 64'd1);
        chk("rstmid_busy",    64'(busy),    64'd0);
        chk("rstmid_re",      64'(re),      64'd0);
        chk("rstmid_we",      64'(we),      64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (120) @(negedge clk);
        clear_q();
        send_write(8'h1F, 32'h00000001);
        settle("after_rst");

        chk("re_we_exclusive", 64'(both_hi), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
